// File: rtl/tt_uart_core.sv
// tt_uart_core: 8N1 UART responder for the console controller.
// Resynchronises tx_clk/rx_clk/rx_in and runs the TX and RX framers.
module tt_uart_core #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_clk,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       tx_empty,
  output logic       tx_out,
  input  logic       rx_clk,
  input  logic       rx_req,
  output logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       rx_in,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int MSB = SYNC_STAGES - 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic [MSB:0] tx_clk_s, rx_clk_s, rx_in_s;
  logic         tx_clk_d, rx_clk_d;
  logic         tx_tick, rx_tick;
  logic         rxd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_clk_s <= '1;
      rx_clk_s <= '1;
      rx_in_s  <= '1;
      tx_clk_d <= 1'b1;
      rx_clk_d <= 1'b1;
      tx_tick  <= 1'b0;
      rx_tick  <= 1'b0;
    end else begin
      tx_clk_s <= {tx_clk_s[MSB-1:0], tx_clk};
      rx_clk_s <= {rx_clk_s[MSB-1:0], rx_clk};
      rx_in_s  <= {rx_in_s[MSB-1:0], rx_in};
      tx_clk_d <= tx_clk_s[MSB];
      rx_clk_d <= rx_clk_s[MSB];
      tx_tick  <= tx_clk_s[MSB] & ~tx_clk_d;
      rx_tick  <= rx_clk_s[MSB] & ~rx_clk_d;
    end
  end

  assign rxd = rx_in_s[MSB];

  st_t        tx_state, tx_next;
  logic       hold_full;
  logic [7:0] hold_data;
  logic [7:0] tx_shreg;
  logic [2:0] tx_bits;
  logic       tx_accept, tx_load, tx_shift, tx_out_next;

  assign tx_accept = tx_req & ~hold_full & ~tx_ack;
  assign tx_empty  = (tx_state == S_IDLE) & ~hold_full;

  always_comb begin
    tx_next     = tx_state;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    tx_out_next = tx_out;
    if (tx_tick) begin
      unique case (tx_state)
        S_IDLE: if (hold_full) begin
          tx_load     = 1'b1;
          tx_out_next = 1'b0;
          tx_next     = S_START;
        end
        S_START: begin
          tx_shift    = 1'b1;
          tx_out_next = tx_shreg[0];
          tx_next     = S_DATA;
        end
        S_DATA: if (tx_bits == 3'd7) begin
          tx_out_next = 1'b1;
          tx_next     = S_STOP;
        end else begin
          tx_shift    = 1'b1;
          tx_out_next = tx_shreg[0];
        end
        // back-to-back: next start bit begins at the tick ending this stop bit
        S_STOP: if (hold_full) begin
          tx_load     = 1'b1;
          tx_out_next = 1'b0;
          tx_next     = S_START;
        end else begin
          tx_next     = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_out    <= 1'b1;
      tx_ack    <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      tx_shreg  <= 8'h00;
      tx_bits   <= 3'd0;
    end else begin
      tx_out <= tx_out_next;
      if (tx_accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
      if (tx_accept)   tx_ack <= 1'b1;
      else if (!tx_req) tx_ack <= 1'b0;
      if (tx_load) begin
        tx_shreg <= hold_data;
        tx_bits  <= 3'd0;
      end else if (tx_shift) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        if (tx_state == S_DATA) tx_bits <= tx_bits + 3'd1;
      end
    end
  end

  st_t          rx_state, rx_next;
  logic [CW-1:0] rx_cnt, rx_cnt_next;
  logic [2:0]   rx_bits, rx_bits_next;
  logic [7:0]   rx_shreg;
  logic         rx_sample, stop_ok, stop_bad, rx_accept;

  assign rx_accept = rx_req & ~rx_ack;

  always_comb begin
    rx_next      = rx_state;
    rx_cnt_next  = rx_cnt;
    rx_bits_next = rx_bits;
    rx_sample    = 1'b0;
    stop_ok      = 1'b0;
    stop_bad     = 1'b0;
    if (rx_tick) begin
      unique case (rx_state)
        S_IDLE: if (!rxd) begin
          rx_next     = S_START;
          rx_cnt_next = '0;
        end
        S_START: if (rx_cnt == HALF) begin
          rx_cnt_next  = '0;
          rx_bits_next = 3'd0;
          rx_next      = rxd ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
        S_DATA: if (rx_cnt == LAST) begin
          rx_sample   = 1'b1;
          rx_cnt_next = '0;
          if (rx_bits == 3'd7) rx_next = S_STOP;
          else rx_bits_next = rx_bits + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
        S_STOP: if (rx_cnt == LAST) begin
          stop_ok  = rxd;
          stop_bad = ~rxd;
          rx_next  = S_IDLE;
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt       <= '0;
      rx_bits      <= 3'd0;
      rx_shreg     <= 8'h00;
      rx_data      <= 8'h00;
      rx_empty     <= 1'b1;
      rx_ack       <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_cnt       <= rx_cnt_next;
      rx_bits      <= rx_bits_next;
      rx_frame_err <= stop_bad;
      if (rx_sample) rx_shreg <= {rxd, rx_shreg[7:1]};
      if (rx_accept)    rx_ack <= 1'b1;
      else if (!rx_req) rx_ack <= 1'b0;
      // a frame landing with the handshake keeps the new byte
      if (stop_ok) begin
        rx_data  <= rx_shreg;
        rx_empty <= 1'b0;
      end else if (rx_accept) begin
        rx_empty <= 1'b1;
      end
      if (stop_ok && !rx_empty && !rx_accept) rx_overrun <= 1'b1;
      else if (rx_accept)                     rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_uart_core.sv
// tb_tt_uart_core: directed scoreboard bench for tt_uart_core.
// tx_clk is 20 clks per bit; rx_clk is 10 clks per tick (160 clks per bit).
module tb_tt_uart_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_clk = 1'b0;
  logic       rx_clk = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_req = 1'b0;
  logic       rx_in = 1'b1;
  logic       tx_ack, tx_empty, tx_out;
  logic       rx_ack, rx_empty, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;

  int vectors = 0;
  int miscompares = 0;
  logic       tx_q[$];
  logic [7:0] rx_q[$];

  tt_uart_core dut (
    .clk(clk), .reset(reset),
    .tx_clk(tx_clk), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_empty(tx_empty), .tx_out(tx_out),
    .rx_clk(rx_clk), .rx_req(rx_req), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_in(rx_in),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  initial begin #3; forever #100 tx_clk = ~tx_clk; end
  initial begin #7; forever #50 rx_clk = ~rx_clk; end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  task automatic tx_capture(input int n);
    int t = 0;
    logic e;
    while (tx_out !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("tx_start_seen", tx_out, 8'h00);
    if (tx_out === 1'b0) begin
      repeat (10) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 1'bx;
        chk($sformatf("tx_bit%0d", i), tx_out, e);
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic do_tx(input logic [7:0] b, output int lat);
    @(negedge clk);
    tx_data = b;
    tx_req  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_ack !== 1'b1 && lat < 100);
    chk("tx_ack_set", tx_ack, 8'h01);
    repeat (3) @(negedge clk);
    chk("tx_ack_held", tx_ack, 8'h01);
    tx_req = 1'b0;
    @(negedge clk);
    chk("tx_ack_clr", tx_ack, 8'h00);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop,
                         input int stop_len);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (160) @(negedge clk);
    end
    rx_in = stop;
    repeat (stop_len) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic rx_check(input string tag);
    int t = 0;
    logic [7:0] e;
    while (rx_empty !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_empty"}, rx_empty, 8'h00);
    while (rx_q.size() > 1) void'(rx_q.pop_front());
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    chk({tag, "_data"}, rx_data, e);
  endtask

  task automatic rx_handshake(input logic [7:0] data_exp);
    @(negedge clk);
    rx_req = 1'b1;
    @(negedge clk);
    chk("rx_ack_set", rx_ack, 8'h01);
    chk("rx_empty_hs", rx_empty, 8'h01);
    chk("rx_overrun_hs", rx_overrun, 8'h00);
    rx_req = 1'b0;
    @(negedge clk);
    chk("rx_ack_clr", rx_ack, 8'h00);
    chk("rx_data_kept", rx_data, data_exp);
  endtask

  initial begin
    int lat;
    int lows;
    int errs;
    int fulls;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_out", tx_out, 8'h01);
    chk("rst_tx_ack", tx_ack, 8'h00);
    chk("rst_tx_empty", tx_empty, 8'h01);
    chk("rst_rx_ack", rx_ack, 8'h00);
    chk("rst_rx_empty", rx_empty, 8'h01);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_frame_err", rx_frame_err, 8'h00);
    chk("rst_overrun", rx_overrun, 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // reset in the middle of a frame
    tx_data = 8'h00;
    tx_req  = 1'b1;
    lows = 0;
    while (tx_out !== 1'b0 && lows < 400) begin
      @(negedge clk);
      lows++;
    end
    chk("midrst_started", tx_out, 8'h00);
    repeat (30) @(negedge clk);
    reset  = 1'b0;
    tx_req = 1'b0;
    #1;
    chk("midrst_tx_out", tx_out, 8'h01);
    chk("midrst_tx_empty", tx_empty, 8'h01);
    chk("midrst_tx_ack", tx_ack, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    chk("midrst_quiet", 8'(lows != 0), 8'h00);
    chk("midrst_empty_after", tx_empty, 8'h01);

    // single byte A5
    push_frame(8'hA5);
    fork
      tx_capture(10);
      begin
        do_tx(8'hA5, lat);
        chk("tx_ack_lat", 8'(lat), 8'h01);
        chk("tx_empty_busy", tx_empty, 8'h00);
      end
    join
    chk("tx_empty_done", tx_empty, 8'h01);
    chk("tx_idle_high", tx_out, 8'h01);

    // back-to-back 41 then 42
    repeat (20) @(negedge clk);
    push_frame(8'h41);
    fork
      tx_capture(20);
      begin
        do_tx(8'h41, lat);
        repeat (80) @(negedge clk);
        push_frame(8'h42);
        do_tx(8'h42, lat);
      end
    join
    chk("b2b_empty_done", tx_empty, 8'h01);

    // receive 3C and hand it over
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 160);
    rx_check("rx3c");
    rx_handshake(8'h3C);

    // overrun: 55 then 66 without handshake
    rx_q.push_back(8'h55);
    send_rx(8'h55, 1'b1, 160);
    chk("ovr_after_first", rx_overrun, 8'h00);
    rx_q.push_back(8'h66);
    send_rx(8'h66, 1'b1, 160);
    chk("ovr_set", rx_overrun, 8'h01);
    rx_check("rx66");
    rx_handshake(8'h66);

    // stop bit low
    errs = 0;
    fulls = 0;
    fork
      send_rx(8'h12, 1'b0, 120);
      repeat (1900) begin
        @(negedge clk);
        if (rx_frame_err === 1'b1) errs++;
        if (rx_empty !== 1'b1) fulls++;
      end
    join
    chk("ferr_pulses", 8'(errs), 8'h01);
    chk("ferr_never_full", 8'(fulls != 0), 8'h00);
    chk("ferr_empty", rx_empty, 8'h01);
    chk("ferr_data", rx_data, 8'h66);

    // 4-tick start glitch
    errs = 0;
    fulls = 0;
    fork
      begin
        @(negedge clk);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        rx_in = 1'b1;
      end
      repeat (600) begin
        @(negedge clk);
        if (rx_frame_err === 1'b1) errs++;
        if (rx_empty !== 1'b1) fulls++;
      end
    join
    chk("glitch_no_ferr", 8'(errs), 8'h00);
    chk("glitch_no_frame", 8'(fulls != 0), 8'h00);
    chk("glitch_data", rx_data, 8'h66);

    // clean frame after the glitch
    rx_q.push_back(8'hC3);
    send_rx(8'hC3, 1'b1, 160);
    rx_check("rxc3");
    chk("rxc3_no_ovr", rx_overrun, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_uart_core.md
Name: tt_uart_core

Overview:
- Serial side of the console path: the 8N1 UART responder that services the console controller's tx_req/tx_ack and rx_req/rx_ack handshakes.
- Converts a handshaked byte into a serial frame on tx_out.
- Deserialises rx_in into a one-deep holding register that the controller drains by handshake.
- Baud timing comes from the baud-rate generator outputs tx_clk/rx_clk, which are asynchronous to clk and are resynchronised here.

Parameters:
- OVERSAMPLE, 16, rx_clk rising edges per bit time; power of 2, minimum 8.
- SYNC_STAGES, 2, flops in each synchroniser (tx_clk, rx_clk, rx_in).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- tx_clk  in  1  1x-baud square wave, async to clk.
- tx_req  in  1  controller requests transmit of tx_data (level).
- tx_data  in  8  byte to send; stable while tx_req=1.
- tx_ack  out  1  byte accepted; held while tx_req=1.
- tx_empty  out  1  holding register and shifter both idle.
- tx_out  out  1  serial line out, idle high.
- rx_clk  in  1  OVERSAMPLE x baud square wave, async to clk.
- rx_req  in  1  controller requests the received byte (level).
- rx_ack  out  1  byte handed over; held while rx_req=1.
- rx_data  out  8  last received byte; holds its value until the next valid frame.
- rx_empty  out  1  no unconsumed byte in the holding register.
- rx_in  in  1  serial line in, async.
- rx_frame_err  out  1  one-clk pulse when a stop bit is sampled low.
- rx_overrun  out  1  sticky; set when a frame completes while the holding register is full; cleared on the rx_ack rising.

Behaviour:
- Reset values: tx_out=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0, rx_frame_err=0, rx_overrun=0. Synchronisers preset to 1; all FSMs return to IDLE. Reset mid-frame aborts immediately and tx_out goes to 1.
- Ticks: each clock input passes through a SYNC_STAGES synchroniser and then a rising-edge detector, giving a one-clk tick. The tick occurs SYNC_STAGES+1 clks after the edge.
- TX accept:
  - If tx_req=1, the holding register is empty and tx_ack=0, latch tx_data into the holding register and set tx_ack on the next clk.
  - tx_ack clears on the clk after tx_req=0.
  - tx_empty drops in the same cycle tx_ack sets.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on a tx tick with the holding register full, move the byte into the shifter, free the holding register and drive tx_out=0 (START).
  - START: on the next tick, drive data bit 0 (LSB first) and enter DATA.
  - DATA: shift one bit per tick under a 3-bit counter. After bit 7 has been held for one tick, drive 1 and enter STOP.
  - STOP: after one full tick period, return to IDLE.
  - tx_empty=1 only in IDLE with the holding register empty.
  - A second byte may be accepted during START/DATA/STOP. It is sent back-to-back, with its start bit beginning at the tick that ends the previous stop bit.
- RX FSM: IDLE -> START -> DATA -> STOP, with a tick counter modulo OVERSAMPLE.
  - IDLE: a synchronised rx_in=0 on an rx tick enters START with count 0.
  - START: at count OVERSAMPLE/2-1, if rx_in=1 it is a glitch and the FSM returns to IDLE. Otherwise the counter resets and the FSM enters DATA.
  - DATA: sample once every OVERSAMPLE ticks, bits 0..7 LSB first into a shift register.
  - STOP: sample after OVERSAMPLE ticks.
    - Stop bit = 1: load rx_data, set rx_empty=0. If rx_empty was already 0, set rx_overrun; the new byte overwrites the old.
    - Stop bit = 0: pulse rx_frame_err and leave rx_data/rx_empty unchanged.
  - STOP then returns to IDLE and can start a new frame immediately.
- RX handshake:
  - If rx_req=1 and rx_ack=0, set rx_ack and rx_empty=1 on the next clk. rx_data is not changed.
  - rx_ack clears on the clk after rx_req=0.
  - rx_req while rx_empty=1 is still acked and hands over stale data; the controller must not do this.
- Simultaneous events: a frame completing in the same cycle as an rx_req accept loads the new byte and leaves rx_empty=0. The handshake consumes the old byte; the new byte is kept.

Test Plan:
- Reset low mid-TX frame, then release -> tx_out=1 and tx_empty=1 in the cycle reset asserts; no further transitions until the next tx_req.
- tx_req with tx_data=8'hA5 -> tx_ack within 1 clk and held until tx_req drops. tx_out sequence, one per tx tick: 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB first, stop). tx_empty returns to 1 after the stop bit.
- Two handshakes, 8'h41 then 8'h42, the second issued during the first frame's data bits -> 20 contiguous bit times with no idle gap between the frames.
- Drive rx_in with frame 8'h3C at 16x timing -> rx_empty=0, rx_data=8'h3C. After the rx_req/rx_ack handshake: rx_empty=1 and rx_data still 8'h3C.
- Drive rx_in with 8'h55 and then 8'h66 without any rx_req -> rx_data=8'h66 and rx_overrun=1. The next rx_ack rising clears rx_overrun.
- Drive rx_in with 8'h12 and the stop bit forced 0 -> rx_frame_err pulses once; rx_empty and rx_data unchanged. A start-bit glitch of 4 rx ticks -> no frame received.
